gearbox_128_132: RTL and testbench
==================================

// Module: gearbox_128_132
// PURPOSE
//   Receive-side inverse of the 132->128 transmit gearbox. Sits directly downstream of it, across the link.
//   Repacks a stream of 128-bit words into 132-bit blocks (4-bit header + 128-bit payload). Bit order is MSB-first.
//   Every 33 input words yield exactly 32 output blocks. Valid/ready on both sides; single clock domain.
// PARAMETERS
//   IN_W    128  input word width; only the default is supported
//   OUT_W   132  output block width; only the default is supported
//   NIB     4    granularity of fill accounting (bits); IN_W and OUT_W are multiples of it
//   BUF_W   260  internal buffer width = OUT_W + IN_W; holds up to 65 nibbles
// PORTS
//   clk         in   1    single clock; all logic rising-edge
//   rst_n       in   1    asynchronous active-low reset
//   din_valid   in   1    upstream word valid
//   din         in   128  input word; din[127] is the earliest bit on the line
//   din_ready   out  1    block can accept din this cycle
//   dout_ready  in   1    downstream can take a block
//   dout_valid  out  1    dout holds a complete 132-bit block
//   dout        out  132  output block; dout[131] is the earliest bit
// BEHAVIOUR
//   State
//   - buf[259:0]: left-justified. Valid bits are buf[259 -: 4*fill]; bits below them are 0.
//   - fill[6:0]: nibble count, 0..65.
//   Reset (async, rst_n=0): buf=0, fill=0 -> dout_valid=0, dout=0.
//   - din_ready=1 from the first cycle after reset, because it is combinational from fill=0.
//   - Reset mid-stream discards the residue. There is no partial-block output.
//   Handshake
//   - dout_valid = (fill >= 33); dout = buf[259:128]. Both come from registers only.
//   - pop  = dout_valid & dout_ready
//   - fillp = fill - (pop ? 33 : 0), 7-bit arithmetic that never underflows.
//   - din_ready = (fillp <= 33). This creates a combinational path dout_ready -> din_ready, which is permitted.
//   - push = din_valid & din_ready
//   Update, one clock
//   - bufp = pop ? buf << 132 : buf
//   - aligned = {din, 132'b0} >> (4*fillp); the shift is 0..132, so din never truncates.
//   - buf  <= push ? (bufp | aligned) : bufp
//   - fill <= fillp + (push ? 32 : 0). The maximum is 65; exceeding it is a design error, so assert fill<=65.
//   Simultaneous pop+push is the normal steady state.
//   Latency
//   - First block: dout_valid rises 2 cycles after the first accepted word (fill 0->32->64).
//   - Afterwards: with din_valid and dout_ready held high, output is back-to-back.
//   - There is exactly one dout_valid=0 bubble per 33 cycles, at fill=32.
//   - Input never stalls in that steady state.
//   Boundaries
//   - dout_ready=0 with fill>=33: dout and dout_valid are held stable (AXI-style, no retraction).
//     din is accepted only while fill<=33.
//   - din_valid=0: no push; buf still drains on pop.
//   - fill=33 with pop and push: fill goes 33->0->32, and din lands at buf[259:132].
//   - X on din while din_valid=0 must not reach buf.
// STRUCTURE
//   - Flops use the shared dffr #(W) (clk, rst_n, d, q) primitive: one instance each for buf and fill.
//     There is no further sub-module.
//   - Shared package/header gearbox_defs: GB_NIB=4, GB_BLK_W=132, GB_WORD_W=128, GB_BLK_NIB=33, GB_WORD_NIB=32.
//     The 132->128 transmit gearbox uses the same constants.
//   - Control is a single counter (fill); there is no separate FSM.
// TESTING
//   1 Reset: rst_n=0 then release.
//     -> dout_valid=0, dout=0, din_ready=1 on the first post-reset edge.
//   2 Single block: push A=128'h0123..., then B=128'hFEDC..., with dout_ready=1.
//     -> After the 2nd push, dout_valid=1 and dout={A, B[127:124]}.
//     -> fill=31 after the pop; the next push is accepted.
//   3 Rate: 33 back-to-back random words, both sides always ready.
//     -> Exactly 32 blocks; their concatenation equals the input concatenation bit-for-bit.
//     -> fill returns to 0.
//   4 Backpressure: dout_ready=0 for 10 cycles while streaming.
//     -> dout stable; din_ready drops once fill>33; no data loss after release.
//   5 Loopback: 32 random 132-bit blocks -> gearbox_132_128 -> this block, random valid/ready gaps on both sides.
//     -> Output identical to the original blocks, in order.
//   6 Reset mid-stream at fill=50.
//     -> fill=0 and dout_valid=0 immediately; the next 33 words again yield 32 correctly aligned blocks.

Source files
------------

// File: rtl/gearbox_128_132_pkg.sv
// gearbox_128_132_pkg: constants shared by the 128<->132 gearboxes
package gearbox_128_132_pkg;
    localparam int GB_NIB = 4;
    localparam int GB_BLK_W = 132;
    localparam int GB_WORD_W = 128;
    localparam logic [6:0] GB_BLK_NIB = 7'd33;
    localparam logic [6:0] GB_WORD_NIB = 7'd32;
    localparam logic [6:0] GB_MAX_NIB = 7'd65;
endpackage

// File: rtl/gearbox_128_132_if.sv
// gearbox_128_132_if: valid/ready stream of W-bit beats
interface gearbox_128_132_if #(parameter int W = 128);
    logic valid;
    logic ready;
    logic [W-1:0] data;
    modport master (output valid, data, input ready);
    modport slave (input valid, data, output ready);
endinterface

// File: rtl/gearbox_128_132_dffr.sv
// dffr: W-bit register with asynchronous active-low clear
module dffr #(parameter int W = 1) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else q <= d;
endmodule

// File: rtl/gearbox_128_132.sv
// gearbox_128_132: repacks 128-bit words into 132-bit blocks, MSB-first
module gearbox_128_132
    import gearbox_128_132_pkg::*;
#(
    parameter int IN_W = GB_WORD_W,
    parameter int OUT_W = GB_BLK_W,
    parameter int NIB = GB_NIB,
    parameter int BUF_W = OUT_W + IN_W
) (
    input logic clk,
    input logic rst_n,
    gearbox_128_132_if.slave din_i,
    gearbox_128_132_if.master dout_o
);
    logic [BUF_W-1:0] buf_q, buf_d, bufp, aligned;
    logic [6:0] fill_q, fill_d, fillp;
    logic [8:0] sh;
    logic pop, push;
    assign dout_o.valid = fill_q >= GB_BLK_NIB;
    assign dout_o.data = buf_q[BUF_W-1 -: OUT_W];
    assign pop = dout_o.valid & dout_o.ready;
    assign fillp = fill_q - (pop ? GB_BLK_NIB : 7'd0);
    assign din_i.ready = fillp <= GB_BLK_NIB;
    assign push = din_i.valid & din_i.ready;
    // buffer is left-justified: a new word lands right after the surviving residue
    assign sh = 9'(fillp) * 9'(NIB);
    assign bufp = pop ? buf_q << OUT_W : buf_q;
    assign aligned = {din_i.data, {OUT_W{1'b0}}} >> sh;
    assign buf_d = push ? (bufp | aligned) : bufp;
    assign fill_d = fillp + (push ? GB_WORD_NIB : 7'd0);
    dffr #(BUF_W) u_buf (.clk(clk), .rst_n(rst_n), .d(buf_d), .q(buf_q));
    dffr #(7) u_fill (.clk(clk), .rst_n(rst_n), .d(fill_d), .q(fill_q));
    a_fill_max: assert property (@(posedge clk) disable iff (!rst_n) fill_q <= GB_MAX_NIB);
endmodule

// File: tb/tb_gearbox_128_132.sv
// tb_gearbox_128_132: directed vector table plus bit-queue scoreboard for multi-cycle sequences
module tb_gearbox_128_132;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gearbox_128_132_if #(128) in_if ();
    gearbox_128_132_if #(132) out_if ();

    gearbox_128_132 dut (.clk(clk), .rst_n(rst_n), .din_i(in_if), .dout_o(out_if));

    localparam logic [127:0] A = 128'h0123456789abcdef_0011223344556677;
    localparam logic [127:0] B = 128'hfedcba9876543210_8899aabbccddeeff;
    localparam logic [127:0] XW = {128{1'bx}};

    typedef struct {
        logic rst_n, v, r;
        logic [127:0] d;
        logic ev, er;
        logic [131:0] ed;
    } vec_t;

    vec_t tv[12];
    int n_vec = 0, n_bad = 0;
    int pops = 0;
    bit mq[$];

    task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // one clock of stimulus, checked against an expected stream of accepted bits
    task automatic cyc(input logic v, input logic [127:0] d, input logic r,
                       output logic acc, output logic [131:0] blk, output logic popped);
        logic ev, er, pm;
        logic [131:0] e;
        @(negedge clk);
        in_if.valid = v;
        in_if.data = d;
        out_if.ready = r;
        #1;
        ev = mq.size() >= 132;
        chk("dout_valid", 132'(out_if.valid), 132'(ev));
        if (ev) begin
            for (int i = 0; i < 132; i++) e[131-i] = mq[i];
            chk("dout", out_if.data, e);
        end
        pm = ev && r;
        er = (mq.size() - (pm ? 132 : 0)) <= 132;
        chk("din_ready", 132'(in_if.ready), 132'(er));
        acc = v && in_if.ready;
        popped = out_if.valid && r;
        blk = out_if.data;
        if (popped) pops++;
        @(posedge clk);
        if (pm) repeat (132) void'(mq.pop_front());
        if (v && er) for (int i = 127; i >= 0; i--) mq.push_back(d[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        #1;
        chk("rst_valid", 132'(out_if.valid), 132'd0);
        chk("rst_dout", out_if.data, 132'd0);
        chk("rst_ready", 132'(in_if.ready), 132'd1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc, popped;
        logic [131:0] blk;
        logic [131:0] blks[32];
        logic [127:0] words[33];
        logic [4223:0] s;
        int wi, ng, budget;
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b1;

        tv[0]  = '{1'b0, 1'b0, 1'b1, A,  1'b0, 1'b1, 132'd0};
        tv[1]  = '{1'b1, 1'b1, 1'b1, A,  1'b0, 1'b1, 132'd0};
        tv[2]  = '{1'b1, 1'b1, 1'b1, B,  1'b0, 1'b1, {A, 4'h0}};
        tv[3]  = '{1'b1, 1'b0, 1'b1, A,  1'b1, 1'b1, {A, B[127:124]}};
        tv[4]  = '{1'b1, 1'b1, 1'b1, A,  1'b0, 1'b1, {B[123:0], 8'h0}};
        tv[5]  = '{1'b1, 1'b0, 1'b0, A,  1'b1, 1'b0, {B[123:0], A[127:120]}};
        tv[6]  = '{1'b1, 1'b1, 1'b0, B,  1'b1, 1'b0, {B[123:0], A[127:120]}};
        tv[7]  = '{1'b1, 1'b0, 1'b1, A,  1'b1, 1'b1, {B[123:0], A[127:120]}};
        tv[8]  = '{1'b1, 1'b0, 1'b1, XW, 1'b0, 1'b1, {A[119:0], 12'h0}};
        tv[9]  = '{1'b1, 1'b1, 1'b1, B,  1'b0, 1'b1, {A[119:0], 12'h0}};
        tv[10] = '{1'b1, 1'b0, 1'b1, A,  1'b1, 1'b1, {A[119:0], B[127:116]}};
        tv[11] = '{1'b0, 1'b0, 1'b1, A,  1'b0, 1'b1, 132'd0};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst_n = tv[i].rst_n;
            in_if.valid = tv[i].v;
            in_if.data = tv[i].d;
            out_if.ready = tv[i].r;
            #1;
            chk($sformatf("v%0d_valid", i), 132'(out_if.valid), 132'(tv[i].ev));
            chk($sformatf("v%0d_ready", i), 132'(in_if.ready), 132'(tv[i].er));
            chk($sformatf("v%0d_dout", i), out_if.data, tv[i].ed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();

        // 33 words back-to-back, both sides ready: exactly 32 blocks, nothing left
        pops = 0;
        for (int i = 0; i < 33; i++) cyc(1'b1, rnd128(), 1'b1, acc, blk, popped);
        for (int i = 0; i < 4; i++) cyc(1'b0, XW, 1'b1, acc, blk, popped);
        chk("rate_blocks", 132'(pops), 132'd32);
        chk("rate_empty_valid", 132'(out_if.valid), 132'd0);

        // backpressure while streaming
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, rnd128(), 1'b1, acc, blk, popped);
        for (int i = 0; i < 10; i++) cyc(1'b1, rnd128(), 1'b0, acc, blk, popped);
        for (int i = 0; i < 12; i++) cyc(1'b0, XW, 1'b1, acc, blk, popped);

        // loopback of 32 blocks packed as 33 words, random gaps on both sides
        do_reset();
        for (int k = 0; k < 32; k++) begin
            blks[k] = {$urandom_range(0, 15), $urandom, $urandom, $urandom, $urandom};
            s[4223-132*k -: 132] = blks[k];
        end
        for (int j = 0; j < 33; j++) words[j] = s[4223-128*j -: 128];
        wi = 0;
        ng = 0;
        budget = 0;
        while (ng < 32 && budget < 600) begin
            cyc(wi < 33 && $urandom_range(0, 3) != 0, (wi < 33) ? words[wi] : XW,
                $urandom_range(0, 2) != 0, acc, blk, popped);
            if (acc) wi++;
            if (popped) begin
                chk($sformatf("loop_blk%0d", ng), blk, blks[ng]);
                ng++;
            end
            budget++;
        end
        chk("loop_count", 132'(ng), 132'd32);

        // reset mid-stream at fill=50, then a clean 33-word run
        do_reset();
        budget = 0;
        while (mq.size() != 200 && budget < 40) begin
            cyc(1'b1, rnd128(), 1'b1, acc, blk, popped);
            budget++;
        end
        chk("mid_reached_fill50", 132'(mq.size()), 132'd200);
        do_reset();
        pops = 0;
        for (int i = 0; i < 33; i++) cyc(1'b1, rnd128(), 1'b1, acc, blk, popped);
        for (int i = 0; i < 4; i++) cyc(1'b0, XW, 1'b1, acc, blk, popped);
        chk("mid_blocks", 132'(pops), 132'd32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
